mem_bank: RTL and testbench
===========================

// Module: mem_bank
// PURPOSE
//  Parametrised single-port synchronous memory with a valid/ready request channel and a
//  valid/ready read-response channel. Adds byte-enable writes, configurable read latency,
//  range checking and a credit-limited response buffer. Intended as the general memory
//  building block behind the core's load/store path.
// PARAMETERS
//  DATA_W     64    data width in bits; must be a multiple of 8
//  ADDR_W     16    word-address width
//  DEPTH      1024  number of words; DEPTH <= 2**ADDR_W
//  RD_LAT     2     read pipeline stages, >= 1
//  RSP_DEPTH  4     response buffer entries; also the maximum number of outstanding reads
// PORTS
//  clk        in   1         clock; all state changes on the rising edge
//  rst_n      in   1         asynchronous active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         request can be accepted
//  req_we     in   1         1 = write, 0 = read
//  req_addr   in   ADDR_W    word address
//  req_wdata  in   DATA_W    write data
//  req_be     in   DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]
//  rsp_valid  out  1         read response present
//  rsp_ready  in   1         consumer takes the response
//  rsp_rdata  out  DATA_W    read data
//  rsp_err    out  1         response is for an out-of-range address
// BEHAVIOUR
//  - Reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Pipeline, buffer and the
//    outstanding counter are cleared. Array contents are NOT reset. When a reset arrives
//    mid-operation, all in-flight reads are discarded and no response is emitted for them.
//  - Accept: a request is accepted at a clock edge when req_valid && req_ready.
//  - req_ready = (outstanding < RSP_DEPTH). It is driven from registered state only and
//    does not depend on req_valid or rsp_ready in the same cycle.
//    outstanding = reads accepted but not yet handshaken on the response channel.
//    - On an accepted read, outstanding increments.
//    - On a rsp_valid && rsp_ready handshake, outstanding decrements.
//    - When both happen in the same cycle, outstanding is unchanged.
//  - Write: at the accept edge, each byte with req_be[i]=1 is updated. Bytes with
//    req_be[i]=0 keep their old value. A write never produces a response. A write with
//    req_addr >= DEPTH is dropped silently.
//  - Read: the array is sampled at the accept edge. Data enters an RD_LAT-stage pipeline
//    that never stalls; credits guarantee buffer space. Results enter a RSP_DEPTH FIFO in
//    acceptance order.
//    - If the buffer is empty, rsp_valid rises RD_LAT cycles after the accept edge.
//    - For an address >= DEPTH, the response is rdata=0 with rsp_err=1.
//  - Ordering: at most one request per cycle. A read accepted in the cycle after a write
//    to the same address returns the new data. Responses are returned strictly in order.
//  - Response channel: rsp_rdata and rsp_err are held stable while rsp_valid && !rsp_ready.
//    When no response is pending, rsp_rdata=0 and rsp_err=0.
// TESTING
//  1. Write 2017 to addr 0 with be=all 1s; the next cycle, read addr 0 with rsp_ready=1
//     -> rsp_valid 2 cycles after accept, rdata=2017, err=0.
//  2. Write 64'h1111_2222_3333_4444 to addr 5, then write 64'hFFFF_FFFF_FFFF_FFFF with
//     be=8'h0F, then read addr 5 -> rdata=64'h1111_2222_FFFF_FFFF.
//  3. Hold rsp_ready=0 and issue 6 reads back-to-back -> req_ready=0 after the 4th accept.
//     Then raise rsp_ready -> exactly 4 then 2 responses, all in order, none lost.
//  4. Read addr 1024 (DEPTH=1024) -> rdata=0, err=1. Write to addr 2000, then read
//     addr 0 -> addr 0 contents unchanged.
//  5. Hold rsp_ready=1 and read every cycle for 20 cycles -> req_ready stays 1 throughout,
//     with one response per cycle after the initial latency.
//  6. Pulse rst_n=0 with 2 reads in flight -> rsp_valid=0 immediately and req_ready=1.
//     No stale responses appear; data written before the reset is still readable.

Source files
------------

// File: rtl/mem_bank.sv
// Single-port word memory with byte-enable writes, valid/ready request and read-response channels.
// Read latency RD_LAT cycles from accept edge to rsp_valid when the response buffer is empty.
// req_ready falls once RSP_DEPTH reads are outstanding; the read pipeline never stalls.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr                1 = write / 0 = read, word address
//   req_wdata, req_be               write data and per-byte enables
//   rsp_valid/rsp_ready             read-response handshake
//   rsp_rdata, rsp_err              read data, out-of-range flag (both 0 when idle)

// Small FIFO used as the response buffer. Pushes are always accepted: the caller
// guarantees space. pop_dat is forced to zero while empty.
module mem_bank_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_vld = (count != '0);
    assign pop     = pop_vld && pop_rdy;
    assign pop_dat = pop_vld ? store[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_vld) begin
            store[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_vld, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mem_bank #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OUT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [OUT_W-1:0]  outstanding;
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              rsp_hs;

    // Read pipeline: stage 0 is the array sample taken at the accept edge.
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_err;
    logic [DATA_W-1:0] pipe_dat [RD_LAT];

    assign accept   = req_valid && req_ready;
    assign rd_acc   = accept && !req_we;
    assign wr_acc   = accept && req_we;
    assign in_range = ({1'b0, req_addr} < DEPTH_LIM);
    assign idx      = req_addr[IDX_W-1:0];
    assign rsp_hs   = rsp_valid && rsp_ready;

    // Credits cover both pipeline and buffer, so the buffer can never overflow.
    assign req_ready = (outstanding < OUT_W'(RSP_DEPTH));

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Data/err travel unreset; only the valid bits matter after a reset.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            pipe_dat[0] <= in_range ? mem[idx] : '0;
            pipe_err[0] <= !in_range;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_dat[i] <= pipe_dat[i-1];
            pipe_err[i] <= pipe_err[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({rd_acc, rsp_hs})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    mem_bank_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (pipe_vld[RD_LAT-1]),
        .push_dat ({pipe_err[RD_LAT-1], pipe_dat[RD_LAT-1]}),
        .pop_vld  (rsp_valid),
        .pop_rdy  (rsp_ready),
        .pop_dat  ({rsp_err, rsp_rdata})
    );
endmodule

// File: tb/tb_mem_bank.sv
// Self-checking bench for mem_bank: directed scenarios plus a randomized phase,
// all responses scored against a behavioural memory model and expected-response queue.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_mem_bank;
    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 16;
    localparam int DEPTH     = 1024;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [7:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    mem_bank #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        e;
        int          c;
    } exp_t;

    logic [63:0] model_mem [DEPTH];
    exp_t        exp_q[$];
    int          hs_cyc[$];
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: sees every handshake just before the edge that commits it.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            chk("req_ready_credit", 64'(req_ready), 64'(exp_q.size() < RSP_DEPTH));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_spurious", 64'(rsp_valid), 64'd0);
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0].d);
                    chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].e));
                    chk("rsp_latency", 64'(cyc >= exp_q[0].c + RD_LAT), 64'd1);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        rsp_cnt++;
                        hs_cyc.push_back(cyc);
                    end
                end
            end else begin
                chk("rsp_idle_rdata", rsp_rdata, 64'd0);
                chk("rsp_idle_err", 64'(rsp_err), 64'd0);
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    if (int'(req_addr) < DEPTH) begin
                        for (int b = 0; b < 8; b++) begin
                            if (req_be[b]) model_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                        end
                    end
                end else begin
                    exp_t e;
                    e.d = 64'd0;
                    e.e = 1'b1;
                    if (int'(req_addr) < DEPTH) begin
                        e.d = model_mem[req_addr];
                        e.e = 1'b0;
                    end
                    e.c = cyc + 1;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
    task automatic issue(input logic we, input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("issue_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    // Read with rsp_ready=1 into an empty buffer and compare the response directly.
    task automatic read_direct(input string tag, input logic [15:0] a, input logic [63:0] ed, input logic ee);
        int n;
        rsp_ready = 1'b1;
        issue(1'b0, a, 64'd0, 8'h00);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_rdata"}, rsp_rdata, ed);
        chk({tag, "_err"}, 64'(rsp_err), 64'(ee));
        drain();
    endtask

    initial begin
        int base;
        int seen;
        logic [15:0] a;
        int r;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Give every address the bench reads a known value.
        for (int i = 0; i < 16; i++) issue(1'b1, 16'(i), {$urandom, $urandom}, 8'hFF);
        for (int i = 1016; i < 1024; i++) issue(1'b1, 16'(i), {$urandom, $urandom}, 8'hFF);

        // 1: write then read-after-write, exact latency with an empty buffer.
        rsp_ready = 1'b1;
        issue(1'b1, 16'd0, 64'd2017, 8'hFF);
        issue(1'b0, 16'd0, 64'd0, 8'h00);
        @(negedge clk);
        chk("t1_lat_c0", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("t1_lat_c1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid_c2", 64'(rsp_valid), 64'd1);
        chk("t1_rdata", rsp_rdata, 64'd2017);
        chk("t1_err", 64'(rsp_err), 64'd0);
        drain();

        // 2: partial byte-enable write.
        issue(1'b1, 16'd5, 64'h1111_2222_3333_4444, 8'hFF);
        issue(1'b1, 16'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        read_direct("t2", 16'd5, 64'h1111_2222_FFFF_FFFF, 1'b0);

        // 3: credit limit with a stalled consumer, then release.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, 16'(i), 64'd0, 8'h00);
        @(negedge clk);
        chk("t3_ready_low", 64'(req_ready), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t3_rsp_held", 64'(rsp_valid), 64'd1);
        end
        step();
        base = rsp_cnt;
        rsp_ready = 1'b1;
        issue(1'b0, 16'd4, 64'd0, 8'h00);
        issue(1'b0, 16'd5, 64'd0, 8'h00);
        drain();
        chk("t3_rsp_count", 64'(rsp_cnt - base), 64'd6);

        // 4: out-of-range read and dropped out-of-range write.
        read_direct("t4_oor", 16'd1024, 64'd0, 1'b1);
        issue(1'b1, 16'd2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        read_direct("t4_addr0", 16'd0, 64'd2017, 1'b0);

        // 5: full-rate streaming.
        rsp_ready = 1'b1;
        hs_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            issue(1'b0, 16'(i % 16), 64'd0, 8'h00);
            chk("t5_ready", 64'(req_ready), 64'd1);
        end
        drain();
        chk("t5_count", 64'(hs_cyc.size()), 64'd20);
        chk("t5_one_per_cycle", 64'((hs_cyc.size() == 20) ? hs_cyc[19] - hs_cyc[0] : -1), 64'd19);

        // 6: reset with reads in flight.
        rsp_ready = 1'b0;
        issue(1'b0, 16'd0, 64'd0, 8'h00);
        issue(1'b0, 16'd5, 64'd0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_req_ready", 64'(req_ready), 64'd1);
        chk("t6_rsp_rdata", rsp_rdata, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("t6_no_stale", 64'(seen), 64'd0);
        step();
        read_direct("t6_addr0", 16'd0, 64'd2017, 1'b0);
        read_direct("t6_addr5", 16'd5, 64'h1111_2222_FFFF_FFFF, 1'b0);

        // Randomized mix of reads, byte-enable writes, idles and consumer stalls.
        for (int n = 0; n < 400; n++) begin
            rsp_ready = (exp_q.size() >= RSP_DEPTH) ? 1'b1 : ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 31);
            if (r < 16)      a = 16'(r);
            else if (r < 24) a = 16'(1000 + r);
            else             a = 16'(1024 + (r - 24) * 7000);
            issue($urandom_range(0, 2) == 0, a, {$urandom, $urandom}, 8'($urandom));
            if ($urandom_range(0, 4) == 0) step();
        end
        rsp_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
